debug_controller: RTL and testbench

Parametrised run-control and readout block placed between the processor and its memories in the top-level computer. It gates processor execution through run/halt/single-step/breakpoint control. It also provides one handshaked read port that reads any of NUM_CHANNELS display sources (register file, data memory, instruction memory, …) through a shared display address. This replaces free-running execution and per-source display address pins with one uniform, latency-aware debug interface.

---
 rtl/debug_pkg.sv | 19 +
 rtl/debug_read_port.sv | 72 +++++++
 rtl/debug_controller.sv | 118 +++++++++++
 tb/tb_debug_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
`default_nettype none
// debug_pkg: run-control state type and cycle-counter constants shared by the debug blocks. Rev 1.0
package debug_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } dbg_state_t;

  localparam int CYCLE_COUNT_W = 32;
  localparam logic [CYCLE_COUNT_W-1:0] CYCLE_COUNT_MAX = {CYCLE_COUNT_W{1'b1}};

  function automatic logic [CYCLE_COUNT_W-1:0] sat_inc(input logic [CYCLE_COUNT_W-1:0] value);
    return (value == CYCLE_COUNT_MAX) ? value : value + CYCLE_COUNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_read_port.sv
`default_nettype none
// debug_read_port: one-outstanding handshaked read of NUM_CHANNELS display sources sharing one address. Rev 1.0
module debug_read_port #(
  parameter int NUM_CHANNELS = 3,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           rd_req,
  input  logic [CH_W-1:0]                rd_channel,
  input  logic [ADDR_W-1:0]              rd_address,
  output logic                           rd_ready,
  output logic                           rd_valid,
  output logic [DATA_W-1:0]              rd_data,
  output logic [ADDR_W-1:0]              channel_address,
  input  logic [NUM_CHANNELS*DATA_W-1:0] channel_data
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  logic              busy;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CH_W-1:0]   channel_sel;
  logic [DATA_W-1:0] sel_data;
  logic              accept;

  assign rd_ready = !busy;
  assign accept   = rd_req && !busy;

  // Channels outside the populated range fall through to zero.
  always_comb begin
    sel_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (channel_sel == CH_W'(c)) begin
        sel_data = channel_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy            <= 1'b0;
      wait_cnt        <= '0;
      channel_sel     <= '0;
      channel_address <= '0;
      rd_valid        <= 1'b0;
      rd_data         <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        busy            <= 1'b1;
        wait_cnt        <= CNT_LOAD;
        channel_sel     <= rd_channel;
        channel_address <= rd_address;
      end else if (busy) begin
        if (wait_cnt == '0) begin
          busy     <= 1'b0;
          rd_valid <= 1'b1;
          rd_data  <= sel_data;
        end else begin
          wait_cnt <= wait_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_controller.sv
`default_nettype none
// debug_controller: run/halt/step/breakpoint gating of the processor, cycle counter and debug read port. Rev 1.0
// Breakpoint compare is compiled in only when DEBUG_BREAKPOINT_EN is defined.
module debug_controller
  import debug_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           halt,
  input  logic                           step,
  input  logic [DATA_W-1:0]              pc,
  input  logic [DATA_W-1:0]              bp_address,
  output logic                           cpu_enable,
  output logic                           halted,
  output logic [CYCLE_COUNT_W-1:0]       cycle_count,
  input  logic                           rd_req,
  input  logic [CH_W-1:0]                rd_channel,
  input  logic [ADDR_W-1:0]              rd_address,
  output logic                           rd_ready,
  output logic                           rd_valid,
  output logic [DATA_W-1:0]              rd_data,
  output logic [ADDR_W-1:0]              channel_address,
  input  logic [NUM_CHANNELS*DATA_W-1:0] channel_data
);

  dbg_state_t               state;
  logic                     first_run;
  logic                     bp_hit;
  logic [CYCLE_COUNT_W-1:0] cycle_cnt;

`ifdef DEBUG_BREAKPOINT_EN
  // The first RUN cycle after leaving HALTED is exempt so resuming at the breakpoint PC makes progress.
  assign bp_hit = (state == RUN) && !first_run && (pc == bp_address);
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{pc, bp_address, first_run};
  assign bp_hit = 1'b0;
`endif

  // Combinational so the instruction sitting at the breakpoint never gets its enable.
  assign cpu_enable = ((state == RUN) && !bp_hit) || (state == STEP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HALTED;
      halted    <= 1'b1;
      first_run <= 1'b0;
    end else begin
      first_run <= 1'b0;
      case (state)
        HALTED: begin
          if (!halt) begin
            if (step) begin
              state  <= STEP;
              halted <= 1'b0;
            end else if (run) begin
              state     <= RUN;
              halted    <= 1'b0;
              first_run <= 1'b1;
            end
          end
        end
        RUN: begin
          if (halt || bp_hit) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        STEP: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (cpu_enable) begin
      cycle_cnt <= sat_inc(cycle_cnt);
    end
  end

  assign cycle_count = cycle_cnt;

  debug_read_port #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY),
    .CH_W         (CH_W)
  ) u_read_port (
    .clock           (clock),
    .reset           (reset),
    .rd_req          (rd_req),
    .rd_channel      (rd_channel),
    .rd_address      (rd_address),
    .rd_ready        (rd_ready),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .channel_address (channel_address),
    .channel_data    (channel_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_debug_controller.sv
`default_nettype none
// tb_debug_controller: command vector table, hand-written corner sequences and a randomized reference-model run.
module tb_debug_controller;

  localparam int NCH = 3;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int RL  = 2;
`ifdef DEBUG_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              run, halt, step;
  logic [DW-1:0]     pc, bp_address;
  logic              cpu_enable, halted;
  logic [31:0]       cycle_count;
  logic              rd_req;
  logic [1:0]        rd_channel;
  logic [AW-1:0]     rd_address;
  logic              rd_ready, rd_valid;
  logic [DW-1:0]     rd_data;
  logic [AW-1:0]     channel_address;
  logic [NCH*DW-1:0] channel_data;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  debug_controller #(
    .NUM_CHANNELS (NCH),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .READ_LATENCY (RL)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .run             (run),
    .halt            (halt),
    .step            (step),
    .pc              (pc),
    .bp_address      (bp_address),
    .cpu_enable      (cpu_enable),
    .halted          (halted),
    .cycle_count     (cycle_count),
    .rd_req          (rd_req),
    .rd_channel      (rd_channel),
    .rd_address      (rd_address),
    .rd_ready        (rd_ready),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .channel_address (channel_address),
    .channel_data    (channel_data)
  );

  // Display source contents; channel 1 holds 0xDEADBEEF at address 5.
  function automatic logic [31:0] src(input int c, input logic [AW-1:0] a);
    if (c == 1 && a == 6'd5) return 32'hDEAD_BEEF;
    return (32'(c + 1) << 28) ^ {26'h0, a} ^ 32'h0055_AA00;
  endfunction

  // Sources with READ_LATENCY-1 register stages behind the shared address.
  always @(posedge clock) begin
    for (int c = 0; c < NCH; c++) channel_data[c*DW +: DW] <= src(c, channel_address);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0;
    rd_req = 1'b0; rd_channel = '0; rd_address = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_en"}, 32'(cpu_enable), 0);
    chk({tag, "_halted"}, 32'(halted), 1);
    chk({tag, "_count"}, cycle_count, 0);
    chk({tag, "_ready"}, 32'(rd_ready), 1);
    chk({tag, "_valid"}, 32'(rd_valid), 0);
    chk({tag, "_data"}, rd_data, 0);
    chk({tag, "_caddr"}, 32'(channel_address), 0);
  endtask

  // {run, halt, step, expected cpu_enable, expected halted} after the edge that samples the command
  typedef struct packed {
    logic r; logic h; logic s; logic en; logic hl;
  } cmd_vec_t;

  cmd_vec_t vecs[17];

  typedef struct { int due; logic [31:0] val; } rd_tx_t;
  rd_tx_t pend[$];

  int          mode;   // 0 halted, 1 running, 2 single step
  bit          fresh;
  bit          m_hit, exp_en, exp_valid, exp_ready, en_seen;
  logic [31:0] m_cnt, m_rdata, v, exp_count;
  logic [AW-1:0] m_caddr;

  initial begin
    vecs = '{5'b000_01, 5'b111_01, 5'b001_10, 5'b000_01, 5'b101_10, 5'b101_01,
             5'b100_10, 5'b001_10, 5'b000_10, 5'b110_01, 5'b010_01, 5'b100_10,
             5'b011_01, 5'b001_10, 5'b010_01, 5'b100_10, 5'b010_01};

    pc = 32'h100; bp_address = 32'h10;
    do_reset();
    chk_reset_values("rst");

    // Command table, pc never at the breakpoint
    exp_count = 0;
    for (int i = 0; i < 17; i++) begin
      run = vecs[i].r; halt = vecs[i].h; step = vecs[i].s;
      tick();
      run = 1'b0; halt = 1'b0; step = 1'b0;
      #1;
      chk($sformatf("vec%0d_en", i), 32'(cpu_enable), 32'(vecs[i].en));
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].hl));
      chk($sformatf("vec%0d_count", i), cycle_count, exp_count);
      if (vecs[i].en) exp_count++;
    end

    // Run pulse then five enabled cycles
    do_reset();
    chk("run_pre_en", 32'(cpu_enable), 0);
    run = 1'b1; tick(); run = 1'b0; #1;
    chk("run_en", 32'(cpu_enable), 1);
    for (int i = 0; i < 5; i++) tick();
    chk("run_count5", cycle_count, 5);
    chk("run_halted", 32'(halted), 0);

    // Breakpoint at 0x10 with pc ramping by 4 from 0
    do_reset();
    bp_address = 32'h10; pc = 32'h0;
    run = 1'b1; tick(); run = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      en_seen = cpu_enable;
      chk($sformatf("bp_en%0d", i), 32'(cpu_enable), 32'(!BP_EN || i < 4));
      chk($sformatf("bp_halted%0d", i), 32'(halted), 32'(BP_EN && i >= 5));
      tick();
      if (en_seen) pc = pc + 4;
      #1;
    end
    chk("bp_count", cycle_count, BP_EN ? 32'd4 : 32'd8);

    // Resume with pc sitting on the breakpoint
    halt = 1'b1; tick(); halt = 1'b0; pc = 32'h10; #1;
    chk("resume_pre_halted", 32'(halted), 1);
    run = 1'b1; tick(); run = 1'b0; #1;
    for (int i = 0; i < 6; i++) begin
      en_seen = cpu_enable;
      chk($sformatf("resume_en%0d", i), 32'(cpu_enable), 1);
      chk($sformatf("resume_halted%0d", i), 32'(halted), 0);
      tick();
      if (en_seen) pc = pc + 4;
      #1;
    end
    chk("resume_count", cycle_count, BP_EN ? 32'd10 : 32'd15);

    // Read of channel 1 address 5, with an ignored request while busy
    do_reset();
    rd_req = 1'b1; rd_channel = 2'd1; rd_address = 6'd5;
    tick();
    rd_channel = 2'd2; rd_address = 6'd7; #1;
    chk("rd_caddr", 32'(channel_address), 5);
    chk("rd_busy", 32'(rd_ready), 0);
    chk("rd_valid_early", 32'(rd_valid), 0);
    tick();
    rd_req = 1'b0; #1;
    chk("rd_caddr_hold", 32'(channel_address), 5);
    chk("rd_valid_early2", 32'(rd_valid), 0);
    tick(); #1;
    chk("rd_valid", 32'(rd_valid), 1);
    chk("rd_data", rd_data, 32'hDEAD_BEEF);
    chk("rd_ready_back", 32'(rd_ready), 1);
    tick(); #1;
    chk("rd_valid_pulse", 32'(rd_valid), 0);
    chk("rd_data_hold", rd_data, 32'hDEAD_BEEF);

    // Out-of-range channel returns zero
    rd_req = 1'b1; rd_channel = 2'd3; rd_address = 6'd9;
    tick(); rd_req = 1'b0; tick(); tick(); #1;
    chk("rd_ch3_valid", 32'(rd_valid), 1);
    chk("rd_ch3_data", rd_data, 0);

    // Counter saturation
    do_reset();
    pc = 32'h100; bp_address = 32'h10;
    run = 1'b1; tick(); run = 1'b0;
    @(negedge clock);
    force dut.cycle_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.cycle_cnt;
    tick(); chk("sat_fe", cycle_count, 32'hFFFF_FFFE);
    tick(); chk("sat_ff", cycle_count, 32'hFFFF_FFFF);
    tick(); chk("sat_hold", cycle_count, 32'hFFFF_FFFF);

    // Reset during an outstanding read
    rd_req = 1'b1; rd_channel = 2'd1; rd_address = 6'd5;
    tick();
    rd_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk_reset_values("midrd");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("midrd_novalid%0d", i), 32'(rd_valid), 0);
    end

    // Randomized traffic against the reference model
    do_reset();
    bp_address = 32'h10;
    mode = 0; fresh = 1'b0; m_cnt = 0; m_rdata = 0; m_caddr = 0;
    pend.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      run  = ($urandom_range(0, 7) == 0);
      halt = ($urandom_range(0, 11) == 0);
      step = ($urandom_range(0, 5) == 0);
      pc   = 32'h10 + 32'($urandom_range(0, 3)) * 4;
      rd_req     = 1'($urandom_range(0, 1));
      rd_channel = 2'($urandom_range(0, 3));
      rd_address = 6'($urandom_range(0, 63));
      #1;
      m_hit     = BP_EN && mode == 1 && !fresh && pc == bp_address;
      exp_en    = (mode == 1 && !m_hit) || mode == 2;
      exp_valid = pend.size() > 0 && pend[0].due == cyc;
      exp_ready = pend.size() == 0 || exp_valid;
      if (exp_valid) m_rdata = pend[0].val;
      chk("rnd_en", 32'(cpu_enable), 32'(exp_en));
      chk("rnd_halted", 32'(halted), 32'(mode == 0));
      chk("rnd_count", cycle_count, m_cnt);
      chk("rnd_ready", 32'(rd_ready), 32'(exp_ready));
      chk("rnd_valid", 32'(rd_valid), 32'(exp_valid));
      chk("rnd_data", rd_data, m_rdata);
      chk("rnd_caddr", 32'(channel_address), 32'(m_caddr));
      if (exp_en && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (exp_valid) void'(pend.pop_front());
      if (rd_req && exp_ready) begin
        v = (int'(rd_channel) < NCH) ? src(int'(rd_channel), rd_address) : 32'h0;
        pend.push_back('{due: cyc + 1 + RL, val: v});
        m_caddr = rd_address;
      end
      fresh = 1'b0;
      case (mode)
        0: begin
          if (!halt && step) mode = 2;
          else if (!halt && run) begin mode = 1; fresh = 1'b1; end
        end
        1: if (halt || m_hit) mode = 0;
        default: mode = 0;
      endcase
      tick();
    end
    run = 1'b0; halt = 1'b0; step = 1'b0; rd_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
